controlador_reproducao: RTL and testbench
=========================================

Name: controlador_reproducao

Overview:
Playback controller that sequences the per-song address counter (ASM_endereco_atual). It turns the user's play/pause, next-track and previous-track buttons into the counter's count enable and restart pulse. It also drives the song-index bits that form the upper part of the memory address, and advances the playlist when the counter reports end of song. It runs in the 3 kHz address clock domain.

Parameters:
NUM_MUSICAS, 4, number of songs in memory; valid song indices are 0..NUM_MUSICAS-1
MUSICA_W, 2, width of the song index; must satisfy 2^MUSICA_W >= NUM_MUSICAS
LIMIAR_VOLTA, 9000, address threshold for "previous" (3 s at 3000 addr/s); at or above it, "previous" restarts the current song

Ports:
clk  input  1  system clock, 3 kHz
reset  input  1  reset; synchronous, active-high
play_pause  input  1  play/pause button, level, active-high
prox  input  1  next-track button, level, active-high
ant  input  1  previous-track button, level, active-high
repetir  input  1  1 = wrap to song 0 after the last song; 0 = stop
fim_musica  input  1  end-of-song flag (prox_musica) from the address counter
endereco_atual  input  22  current in-song address from the address counter
count  output  1  count enable to the address counter
reset_endereco  output  1  one-cycle restart pulse to the address counter
musica  output  MUSICA_W  current song index (upper address bits)
tocando  output  1  1 while in TOCANDO
troca  output  1  one-cycle pulse whenever musica changes or the song restarts

Behaviour:
- Only clk is used. reset is sampled on the rising edge of clk, active-high.
- While reset=1:
  - state=PARADO, musica=0, count=0, tocando=0, reset_endereco=0, troca=0.
  - Each edge-detect register is loaded with its live input, so a button held through reset does not fire.
- Edge detection on play_pause, prox, ant and fim_musica:
  - event = input & ~input_q, where input_q is that input registered one cycle.
  - A held button fires exactly once.
- Event priority within a single cycle: fim_musica > prox > ant > play_pause. Lower-priority events in the same cycle are discarded, not queued.
- All outputs are registered. An event sampled at edge N takes effect at edge N+1.
- States: PARADO (stopped), TOCANDO (playing), PAUSADO (paused).
- "Restart" action:
  - reset_endereco=1 and troca=1 for exactly one cycle.
  - count=0 during that cycle, regardless of state.
- count = 1 only when state=TOCANDO and reset_endereco=0.
- tocando = (state==TOCANDO).
- PARADO:
  - play_pause -> TOCANDO, with restart.
  - prox: musica = musica+1, wrapping NUM_MUSICAS-1 -> 0; restart; stay in PARADO.
  - ant: musica = musica-1, wrapping 0 -> NUM_MUSICAS-1; restart; stay in PARADO.
  - fim_musica: ignored.
- TOCANDO:
  - play_pause -> PAUSADO, no restart; count drops the next cycle.
  - prox: next song (wrapping), restart, stay in TOCANDO.
  - ant, endereco_atual >= LIMIAR_VOLTA: musica unchanged, restart.
  - ant, endereco_atual < LIMIAR_VOLTA: previous song (wrapping), restart.
  - fim_musica, musica < NUM_MUSICAS-1: musica+1, restart, stay in TOCANDO.
  - fim_musica, last song, repetir=1: musica=0, restart, stay in TOCANDO.
  - fim_musica, last song, repetir=0: musica=0, restart, go to PARADO.
- PAUSADO:
  - play_pause -> TOCANDO, no restart; the address resumes where it stopped.
  - prox/ant: same song selection as TOCANDO, restart, stay in PAUSADO.
  - fim_musica: ignored.
- fim_musica may stay high for several cycles, since the counter clears itself. Only its rising edge is acted on, and only in TOCANDO, so each song end advances the playlist exactly once.
- Reset asserted mid-restart-pulse: reset wins and all outputs are 0 on the next edge.
- musica never takes a value >= NUM_MUSICAS.

Test Plan:
- Hold reset 3 cycles with play_pause=1, release with it still held -> no transition; state PARADO, musica=0, count=0, reset_endereco=0 throughout.
- From PARADO, pulse play_pause -> one cycle later tocando=1, reset_endereco=1, troca=1, count=0; the following cycle count=1 and reset_endereco=0.
- NUM_MUSICAS=4, TOCANDO, musica=3:
  - repetir=1, fim_musica held high 5 cycles -> musica=0, one restart pulse, still TOCANDO.
  - Repeat with repetir=0 -> musica=0, state PARADO, count=0.
- TOCANDO, musica=2, pulse ant:
  - endereco_atual=12000 -> musica stays 2, restart pulse.
  - endereco_atual=500 -> musica=1, restart pulse.
  - From musica=0 with endereco_atual=500 -> musica=3.
- PAUSADO, pulse play_pause -> count=1 next cycle, no reset_endereco. Pulse prox while PAUSADO -> musica+1, restart pulse, count stays 0.
- prox and play_pause rise in the same cycle while TOCANDO -> only the song changes; state stays TOCANDO; play_pause is not acted on later while still held.

Source files
------------

// File: rtl/controlador_reproducao.sv
// controlador_reproducao
// Playback controller for the per-song address counter. It turns the
// play/pause, next and previous buttons into the counter's count enable and
// a one-cycle restart pulse. It drives the song index that forms the upper
// address bits, and it advances the playlist when the counter reports the
// end of a song. It runs in the 3 kHz address clock domain.
//
// Ports:
//   clk            3 kHz system clock
//   reset          synchronous, active-high reset
//   play_pause     play/pause button (level, active-high)
//   prox           next-track button (level, active-high)
//   ant            previous-track button (level, active-high)
//   repetir        1 = wrap to song 0 after the last song, 0 = stop
//   fim_musica     end-of-song flag from the address counter
//   endereco_atual current in-song address from the address counter
//   count          count enable to the address counter
//   reset_endereco one-cycle restart pulse to the address counter
//   musica         current song index (upper address bits)
//   tocando        high while playing
//   troca          one-cycle pulse when the song changes or restarts
module controlador_reproducao #(
  parameter int NUM_MUSICAS  = 4,
  parameter int MUSICA_W     = 2,
  parameter int LIMIAR_VOLTA = 9000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                play_pause,
  input  logic                prox,
  input  logic                ant,
  input  logic                repetir,
  input  logic                fim_musica,
  input  logic [21:0]         endereco_atual,
  output logic                count,
  output logic                reset_endereco,
  output logic [MUSICA_W-1:0] musica,
  output logic                tocando,
  output logic                troca
);

  typedef enum logic [1:0] {
    PARADO  = 2'd0,
    TOCANDO = 2'd1,
    PAUSADO = 2'd2
  } state_t;

  localparam logic [MUSICA_W-1:0] ULTIMA = MUSICA_W'(NUM_MUSICAS - 1);
  localparam logic [21:0]         LIMIAR = 22'(LIMIAR_VOLTA);

  state_t              state, state_next;
  logic [MUSICA_W-1:0] musica_next;
  logic                restart_next;

  logic play_pause_q, prox_q, ant_q, fim_q;
  logic ev_play_pause, ev_prox, ev_ant, ev_fim;

  logic [MUSICA_W-1:0] musica_mais, musica_menos, musica_anterior;

  // Rising-edge events: a held button fires only once.
  assign ev_play_pause = play_pause & ~play_pause_q;
  assign ev_prox       = prox & ~prox_q;
  assign ev_ant        = ant & ~ant_q;
  assign ev_fim        = fim_musica & ~fim_q;

  // Song selection helpers with wrap-around. "Previous" past the address
  // threshold means restart the current song rather than go back one.
  always_comb begin
    musica_mais     = (musica == ULTIMA) ? '0 : musica + 1'b1;
    musica_menos    = (musica == '0) ? ULTIMA : musica - 1'b1;
    musica_anterior = (endereco_atual >= LIMIAR) ? musica : musica_menos;
  end

  // Next-state logic. The if/else chain encodes event priority
  // fim_musica > prox > ant > play_pause; lower-priority events in the same
  // cycle are dropped. End-of-song only matters while playing, so an
  // ignored end-of-song does not block a button press.
  always_comb begin
    state_next   = state;
    musica_next  = musica;
    restart_next = 1'b0;
    case (state)
      PARADO: begin
        if (ev_prox) begin
          musica_next  = musica_mais;
          restart_next = 1'b1;
        end else if (ev_ant) begin
          musica_next  = musica_menos;
          restart_next = 1'b1;
        end else if (ev_play_pause) begin
          state_next   = TOCANDO;
          restart_next = 1'b1;
        end
      end
      TOCANDO: begin
        if (ev_fim) begin
          musica_next  = musica_mais;
          restart_next = 1'b1;
          if (musica == ULTIMA && !repetir) begin
            state_next = PARADO;
          end
        end else if (ev_prox) begin
          musica_next  = musica_mais;
          restart_next = 1'b1;
        end else if (ev_ant) begin
          musica_next  = musica_anterior;
          restart_next = 1'b1;
        end else if (ev_play_pause) begin
          state_next = PAUSADO;
        end
      end
      PAUSADO: begin
        if (ev_prox) begin
          musica_next  = musica_mais;
          restart_next = 1'b1;
        end else if (ev_ant) begin
          musica_next  = musica_anterior;
          restart_next = 1'b1;
        end else if (ev_play_pause) begin
          state_next = TOCANDO;
        end
      end
      default: begin
        state_next  = PARADO;
        musica_next = '0;
      end
    endcase
  end

  // State and registered outputs. During reset the edge-detect registers
  // track their live inputs so a button held through reset never fires.
  // Count is suppressed during a restart cycle even while playing.
  always_ff @(posedge clk) begin
    play_pause_q <= play_pause;
    prox_q       <= prox;
    ant_q        <= ant;
    fim_q        <= fim_musica;
    if (reset) begin
      state          <= PARADO;
      musica         <= '0;
      count          <= 1'b0;
      reset_endereco <= 1'b0;
      troca          <= 1'b0;
      tocando        <= 1'b0;
    end else begin
      state          <= state_next;
      musica         <= musica_next;
      reset_endereco <= restart_next;
      troca          <= restart_next;
      tocando        <= (state_next == TOCANDO);
      count          <= (state_next == TOCANDO) && !restart_next;
    end
  end

endmodule

// File: tb/tb_controlador_reproducao.sv
// tb_controlador_reproducao
// Directed bench for controlador_reproducao. Stimulus pushes hand-computed
// expected output snapshots, tagged with the cycle they must appear in, into
// a scoreboard queue; an independent monitor compares them on the falling
// edge.
module tb_controlador_reproducao;

  logic        clk = 1'b0;
  logic        reset;
  logic        play_pause, prox, ant, repetir, fim_musica;
  logic [21:0] endereco_atual;
  logic        count, reset_endereco, tocando, troca;
  logic [1:0]  musica;

  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic [1:0]  musica;
    logic        tocando;
    logic        count;
    logic        rst;
    logic        troca;
  } exp_t;

  exp_t sb[$];

  controlador_reproducao #(
    .NUM_MUSICAS (4),
    .MUSICA_W    (2),
    .LIMIAR_VOLTA(9000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .play_pause    (play_pause),
    .prox          (prox),
    .ant           (ant),
    .repetir       (repetir),
    .fim_musica    (fim_musica),
    .endereco_atual(endereco_atual),
    .count         (count),
    .reset_endereco(reset_endereco),
    .musica        (musica),
    .tocando       (tocando),
    .troca         (troca)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every scoreboard entry due in this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("[TB] FAIL %s: entry for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
      end else if (musica !== e.musica || tocando !== e.tocando || count !== e.count ||
                   reset_endereco !== e.rst || troca !== e.troca) begin
        errors++;
        $display("[TB] FAIL %s: got musica=%0d tocando=%b count=%b reset_endereco=%b troca=%b, expected musica=%0d tocando=%b count=%b reset_endereco=%b troca=%b",
                 e.name, musica, tocando, count, reset_endereco, troca,
                 e.musica, e.tocando, e.count, e.rst, e.troca);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic pp, input logic px, input logic an,
                               input logic fim, input logic [21:0] ender,
                               input logic rep);
    play_pause     = pp;
    prox           = px;
    ant            = an;
    fim_musica     = fim;
    endereco_atual = ender;
    repetir        = rep;
  endtask

  // Expect the given outputs 'delay' cycles after the current drive point.
  task automatic checkOutput(input string name, input int delay, input logic [1:0] m,
                             input logic toc, input logic cnt, input logic rst,
                             input logic trc);
    exp_t e;
    e.cyc     = cyc + delay;
    e.name    = name;
    e.musica  = m;
    e.tocando = toc;
    e.count   = cnt;
    e.rst     = rst;
    e.troca   = trc;
    sb.push_back(e);
  endtask

  // Pulse next while playing and expect a restart on song m.
  task automatic proxTocando(input string name, input logic [1:0] m, input logic rep);
    applyStimulus(0, 1, 0, 0, 22'd100, rep);
    checkOutput(name, 1, m, 1, 0, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 22'd100, rep);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1, 0, 0, 0, 22'd0, 1);
    tick();
    // Reset with play_pause held, then release reset with it still held.
    checkOutput("reset_state", 1, 0, 0, 0, 0, 0);
    tick(3);
    reset = 1'b0;
    checkOutput("reset_hold_1", 1, 0, 0, 0, 0, 0);
    checkOutput("reset_hold_3", 3, 0, 0, 0, 0, 0);
    tick(3);
    applyStimulus(0, 0, 0, 0, 22'd0, 1);
    tick();

    // Play from PARADO: restart cycle, then counting.
    applyStimulus(1, 0, 0, 0, 22'd0, 1);
    checkOutput("play_restart", 1, 0, 1, 0, 1, 1);
    checkOutput("play_count", 2, 0, 1, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 22'd0, 1);
    tick(2);

    proxTocando("prox_to_1", 1, 1);
    proxTocando("prox_to_2", 2, 1);
    proxTocando("prox_to_3", 3, 1);

    // End of last song with repeat: wrap to 0, single restart, keep playing.
    applyStimulus(0, 0, 0, 1, 22'd100, 1);
    checkOutput("fim_rep_restart", 1, 0, 1, 0, 1, 1);
    checkOutput("fim_rep_after", 2, 0, 1, 1, 0, 0);
    checkOutput("fim_rep_held", 5, 0, 1, 1, 0, 0);
    tick(5);
    applyStimulus(0, 0, 0, 0, 22'd100, 1);
    tick();

    proxTocando("prox_to_1b", 1, 0);
    proxTocando("prox_to_2b", 2, 0);
    proxTocando("prox_to_3b", 3, 0);

    // End of last song without repeat: wrap to 0 and stop.
    applyStimulus(0, 0, 0, 1, 22'd100, 0);
    checkOutput("fim_stop_restart", 1, 0, 0, 0, 1, 1);
    checkOutput("fim_stop_after", 3, 0, 0, 0, 0, 0);
    tick(3);
    applyStimulus(0, 0, 0, 0, 22'd100, 0);
    tick();

    // Previous from PARADO at song 0 wraps to 3, stays stopped.
    applyStimulus(0, 0, 1, 0, 22'd500, 0);
    checkOutput("ant_parado_wrap", 1, 3, 0, 0, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 22'd500, 0);
    tick();
    // Next from PARADO at 3 wraps to 0.
    applyStimulus(0, 1, 0, 0, 22'd500, 0);
    checkOutput("prox_parado_wrap", 1, 0, 0, 0, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 22'd500, 0);
    tick();

    // Play again, go to song 2.
    applyStimulus(1, 0, 0, 0, 22'd0, 0);
    checkOutput("play_again", 1, 0, 1, 0, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 22'd0, 0);
    tick();
    proxTocando("prox_to_1c", 1, 0);
    proxTocando("prox_to_2c", 2, 0);

    // Previous above threshold restarts the same song.
    applyStimulus(0, 0, 1, 0, 22'd12000, 0);
    checkOutput("ant_above_limiar", 1, 2, 1, 0, 1, 1);
    checkOutput("ant_above_after", 2, 2, 1, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 22'd12000, 0);
    tick();
    // Exactly at threshold still restarts.
    applyStimulus(0, 0, 1, 0, 22'd9000, 0);
    checkOutput("ant_at_limiar", 1, 2, 1, 0, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 22'd9000, 0);
    tick();
    // Below threshold goes back one song.
    applyStimulus(0, 0, 1, 0, 22'd500, 0);
    checkOutput("ant_below_limiar", 1, 1, 1, 0, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 22'd500, 0);
    tick();
    applyStimulus(0, 0, 1, 0, 22'd8999, 0);
    checkOutput("ant_to_0", 1, 0, 1, 0, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 22'd500, 0);
    tick();
    applyStimulus(0, 0, 1, 0, 22'd500, 0);
    checkOutput("ant_wrap_to_3", 1, 3, 1, 0, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 22'd500, 0);
    tick();

    // Pause: count drops, no restart.
    applyStimulus(1, 0, 0, 0, 22'd500, 0);
    checkOutput("pause", 1, 3, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 22'd500, 0);
    tick();
    // End-of-song while paused is ignored.
    applyStimulus(0, 0, 0, 1, 22'd500, 0);
    checkOutput("fim_pausado_ignored", 1, 3, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 22'd500, 0);
    tick();
    // Next while paused: wrap to 0, restart, still paused.
    applyStimulus(0, 1, 0, 0, 22'd500, 0);
    checkOutput("prox_pausado", 1, 0, 0, 0, 1, 1);
    checkOutput("prox_pausado_after", 2, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 22'd500, 0);
    tick(2);
    // Resume: count returns, no restart.
    applyStimulus(1, 0, 0, 0, 22'd500, 0);
    checkOutput("resume", 1, 0, 1, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 22'd500, 0);
    tick();

    // prox and play_pause together: only the song changes, held pp ignored.
    applyStimulus(1, 1, 0, 0, 22'd500, 0);
    checkOutput("simult_restart", 1, 1, 1, 0, 1, 1);
    checkOutput("simult_after", 2, 1, 1, 1, 0, 0);
    checkOutput("simult_held", 3, 1, 1, 1, 0, 0);
    tick(3);
    applyStimulus(0, 0, 0, 0, 22'd500, 0);
    tick();

    // Reset asserted while a restart pulse is on the outputs.
    applyStimulus(0, 1, 0, 0, 22'd500, 0);
    checkOutput("pre_reset_restart", 1, 2, 1, 0, 1, 1);
    tick();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 22'd500, 0);
    checkOutput("reset_mid_pulse", 1, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick(2);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s: never compared, expected at cycle %0d", e.name, e.cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
